// File: rtl/teclado_atm.sv
// teclado_atm: keypad front-end for the ATM controller.
// Synchronises and debounces the raw keypad, forwards PIN digits and assembles
// decimal amounts.
// Ports:
//   clk, reset    - system clock (rising edge), synchronous active-high reset
//   tecla_valida  - raw key-pressed level (asynchronous, bouncy)
//   tecla_cod     - raw key code: 0-9 digit, 0xA BORRAR, 0xB ENTRAR
//   modo_monto    - 0 = PIN mode, 1 = amount mode
//   digito        - last accepted PIN digit
//   digito_stb    - one-cycle pulse per accepted PIN digit
//   monto         - last assembled amount
//   monto_stb     - one-cycle pulse when monto is updated
//   num_digitos   - digits currently held in the amount accumulator
//   tecla_error   - one-cycle pulse on a rejected key
module teclado_atm #(
    parameter int unsigned DEBOUNCE_CICLOS = 16,
    parameter int unsigned MAX_DIGITOS     = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tecla_valida,
    input  logic [3:0]  tecla_cod,
    input  logic        modo_monto,
    output logic [3:0]  digito,
    output logic        digito_stb,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic [3:0]  num_digitos,
    output logic        tecla_error
);

    localparam int unsigned CW         = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CICLOS);
    localparam logic [3:0] NUM_MAX     = 4'(MAX_DIGITOS);
    localparam logic [3:0] COD_BORRAR  = 4'hA;
    localparam logic [3:0] COD_ENTRAR  = 4'hB;

    typedef enum logic [2:0] {
        REPOSO,
        FILTRO,
        ACEPTA,
        PRESIONADA,
        LIBERA
    } estado_t;

    estado_t       estado, estado_sig;
    logic [CW-1:0] cnt, cnt_sig;
    logic [3:0]    cod_q, cod_sig;
    logic          valida_s1, valida_s2;
    logic [3:0]    cod_s1, cod_s2;
    logic          modo_q;
    logic [31:0]   acc, acc_sig;
    logic [3:0]    num_sig, digito_sig;
    logic [31:0]   monto_sig;
    logic          dstb_sig, mstb_sig, err_sig;

    // State, synchronisers and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= REPOSO;
            cnt         <= '0;
            cod_q       <= '0;
            valida_s1   <= 1'b0;
            valida_s2   <= 1'b0;
            cod_s1      <= '0;
            cod_s2      <= '0;
            modo_q      <= 1'b0;
            acc         <= '0;
            num_digitos <= '0;
            digito      <= '0;
            monto       <= '0;
            digito_stb  <= 1'b0;
            monto_stb   <= 1'b0;
            tecla_error <= 1'b0;
        end else begin
            estado      <= estado_sig;
            cnt         <= cnt_sig;
            cod_q       <= cod_sig;
            valida_s1   <= tecla_valida;
            valida_s2   <= valida_s1;
            cod_s1      <= tecla_cod;
            cod_s2      <= cod_s1;
            modo_q      <= modo_monto;
            acc         <= acc_sig;
            num_digitos <= num_sig;
            digito      <= digito_sig;
            monto       <= monto_sig;
            digito_stb  <= dstb_sig;
            monto_stb   <= mstb_sig;
            tecla_error <= err_sig;
        end
    end

    // Debounce FSM: one ACEPTA cycle per physical press
    always_comb begin
        estado_sig = estado;
        cnt_sig    = cnt;
        cod_sig    = cod_q;
        unique case (estado)
            REPOSO: begin
                if (valida_s2) begin
                    cod_sig    = cod_s2;
                    cnt_sig    = CW'(1);
                    estado_sig = FILTRO;
                end
            end
            FILTRO: begin
                if (valida_s2 && (cod_s2 == cod_q)) begin
                    if (cnt == CNT_MAX) estado_sig = ACEPTA;
                    else                cnt_sig    = cnt + CW'(1);
                end else begin
                    cnt_sig    = '0;
                    estado_sig = REPOSO;
                end
            end
            ACEPTA: begin
                cnt_sig    = '0;
                estado_sig = PRESIONADA;
            end
            PRESIONADA: begin
                if (!valida_s2) begin
                    cnt_sig    = CW'(1);
                    estado_sig = LIBERA;
                end
            end
            LIBERA: begin
                if (valida_s2) begin
                    cnt_sig    = '0;
                    estado_sig = PRESIONADA;
                end else if (cnt == CNT_MAX) begin
                    cnt_sig    = '0;
                    estado_sig = REPOSO;
                end else begin
                    cnt_sig    = cnt + CW'(1);
                end
            end
            default: begin
                cnt_sig    = '0;
                estado_sig = REPOSO;
            end
        endcase
    end

    // Key actions; a mode toggle clears the accumulator before any action
    always_comb begin
        acc_sig    = acc;
        num_sig    = num_digitos;
        monto_sig  = monto;
        digito_sig = digito;
        dstb_sig   = 1'b0;
        mstb_sig   = 1'b0;
        err_sig    = 1'b0;
        if (modo_monto != modo_q) begin
            acc_sig = '0;
            num_sig = '0;
        end
        if (estado == ACEPTA) begin
            if (!modo_monto) begin
                if (cod_q <= 4'd9) begin
                    digito_sig = cod_q;
                    dstb_sig   = 1'b1;
                end else begin
                    err_sig = 1'b1;
                end
            end else if (cod_q <= 4'd9) begin
                if (num_sig < NUM_MAX) begin
                    // acc*10 as shift-add; MAX_DIGITOS keeps it below 2^32
                    acc_sig = (acc_sig << 3) + (acc_sig << 1) + 32'(cod_q);
                    num_sig = num_sig + 4'd1;
                end else begin
                    err_sig = 1'b1;
                end
            end else if (cod_q == COD_BORRAR) begin
                acc_sig = '0;
                num_sig = '0;
            end else if (cod_q == COD_ENTRAR) begin
                if (num_sig != 4'd0) begin
                    monto_sig = acc_sig;
                    mstb_sig  = 1'b1;
                    acc_sig   = '0;
                    num_sig   = '0;
                end else begin
                    err_sig = 1'b1;
                end
            end else begin
                err_sig = 1'b1;
            end
        end
    end

endmodule
